snake_game_ctrl: RTL and testbench

- Game sequencer for the snake/food datapath manager.
- Generates the move strobe, arbitrates and filters player direction requests, and pulses food generation after each eat.
- Runs the IDLE/RUN/PAUSE/OVER game flow, keeps score and speeds the game up with score.
- Sits between the button debouncers and the snake/food manager; score and state feed the display.

---
 rtl/snake_game_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_snake_game_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_game_ctrl.sv
// Game sequencer: move strobe, direction filter, score/level and IDLE/RUN/PAUSE/OVER flow.
// Latency: every output is registered, so each input pulse takes effect on the outputs one clock later.
// Backpressure: none; all inputs are single-cycle pulses. Optional hiscore output via SNAKE_HISCORE_EN.
module snake_game_ctrl #(
    parameter int CNT_W       = 24,
    parameter int BASE_PERIOD = 12500000,
    parameter int STEP        = 1000000,
    parameter int MIN_PERIOD  = 2500000,
    parameter int SCORE_W     = 8,
    parameter int LVL_SHIFT   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               pause_i,
    input  logic [1:0]         dir_req_i,
    input  logic               dir_vld_i,
    input  logic               eat_i,
    input  logic               col_i,
    output logic               mgr_rst_o,
    output logic               mv_o,
    output logic [1:0]         dir_o,
    output logic               genf_o,
    output logic [1:0]         state_o,
    output logic [SCORE_W-1:0] score_o,
    output logic [3:0]         level_o
`ifdef SNAKE_HISCORE_EN
    ,
    output logic [SCORE_W-1:0] hiscore_o
`endif
);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_OVER  = 2'b11;

    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam int PW = CNT_W + 4;
    localparam logic [PW-1:0] BASE_W = PW'(BASE_PERIOD);
    localparam logic [PW-1:0] STEP_W = PW'(STEP);
    localparam logic [PW-1:0] MIN_W  = PW'(MIN_PERIOD);
    localparam logic [PW-1:0] ONE_W  = PW'(1);

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [SCORE_W-1:0] LVL_CAP   = SCORE_W'(15);

    logic [1:0]         state_q,   state_d;
    logic               mgr_rst_q, mgr_rst_d;
    logic               mv_q,      mv_d;
    logic               genf_q,    genf_d;
    logic [1:0]         dir_q,     dir_d;
    logic [1:0]         pend_q,    pend_d;
    logic [SCORE_W-1:0] score_q,   score_d;
    logic [3:0]         level_q,   level_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
`ifdef SNAKE_HISCORE_EN
    logic [SCORE_W-1:0] hiscore_q, hiscore_d;
`endif

    logic [PW-1:0]      lvl_reduction;
    logic [PW-1:0]      period;
    logic               move_due;
    logic               dir_reverse;
    logic [SCORE_W-1:0] score_inc;
    logic [SCORE_W-1:0] lvl_raw;
    logic [3:0]         lvl_new;

    // Subtraction is only taken when it cannot drop below the floor, so no underflow.
    always_comb begin
        lvl_reduction = STEP_W * PW'(level_q);
        if (lvl_reduction >= BASE_W - MIN_W) begin
            period = MIN_W;
        end else begin
            period = BASE_W - lvl_reduction;
        end
        // >= rather than == so a level-up that shrinks the period below the
        // current count still fires on the next cycle instead of wrapping.
        move_due = (PW'(cnt_q) + ONE_W) >= period;
    end

    always_comb begin
        dir_reverse = (dir_req_i[1] == dir_q[1]) && (dir_req_i[0] != dir_q[0]);
        score_inc   = (score_q == SCORE_MAX) ? score_q : score_q + 1'b1;
        lvl_raw     = score_inc >> LVL_SHIFT;
        lvl_new     = (lvl_raw > LVL_CAP) ? 4'hF : lvl_raw[3:0];
    end

    always_comb begin
        state_d   = state_q;
        mgr_rst_d = mgr_rst_q;
        mv_d      = 1'b0;
        genf_d    = 1'b0;
        dir_d     = dir_q;
        pend_d    = pend_q;
        score_d   = score_q;
        level_d   = level_q;
        cnt_d     = cnt_q;
`ifdef SNAKE_HISCORE_EN
        hiscore_d = hiscore_q;
`endif

        case (state_q)
            S_IDLE, S_OVER: begin
                // IDLE keeps the manager in reset; OVER leaves the final snake visible.
                mgr_rst_d = (state_q == S_IDLE);
                if (start_i) begin
                    // From OVER the manager still needs one reset cycle.
                    mgr_rst_d = (state_q == S_OVER);
                    state_d   = S_RUN;
                    score_d   = '0;
                    level_d   = '0;
                    cnt_d     = '0;
                    dir_d     = DIR_RIGHT;
                    pend_d    = DIR_RIGHT;
                end
            end

            S_RUN: begin
                mgr_rst_d = 1'b0;
                if (col_i) begin
                    state_d = S_OVER;
`ifdef SNAKE_HISCORE_EN
                    if (score_q > hiscore_q) begin
                        hiscore_d = score_q;
                    end
`endif
                end else begin
                    if (eat_i) begin
                        score_d = score_inc;
                        level_d = lvl_new;
                        genf_d  = 1'b1;
                    end
                    if (pause_i) begin
                        state_d = S_PAUSE;
                    end else begin
                        if (move_due) begin
                            mv_d  = 1'b1;
                            cnt_d = '0;
                            dir_d = pend_q;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                        if (dir_vld_i && !dir_reverse) begin
                            pend_d = dir_req_i;
                        end
                    end
                end
            end

            S_PAUSE: begin
                if (pause_i) begin
                    state_d = S_RUN;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mgr_rst_q <= 1'b1;
            mv_q      <= 1'b0;
            genf_q    <= 1'b0;
            dir_q     <= DIR_RIGHT;
            pend_q    <= DIR_RIGHT;
            score_q   <= '0;
            level_q   <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            mgr_rst_q <= mgr_rst_d;
            mv_q      <= mv_d;
            genf_q    <= genf_d;
            dir_q     <= dir_d;
            pend_q    <= pend_d;
            score_q   <= score_d;
            level_q   <= level_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef SNAKE_HISCORE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hiscore_q <= '0;
        end else begin
            hiscore_q <= hiscore_d;
        end
    end

    assign hiscore_o = hiscore_q;
`endif

    assign mgr_rst_o = mgr_rst_q;
    assign mv_o      = mv_q;
    assign dir_o     = dir_q;
    assign genf_o    = genf_q;
    assign state_o   = state_q;
    assign score_o   = score_q;
    assign level_o   = level_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Randomized scoreboard bench for snake_game_ctrl with a game-rule reference model.
module tb_snake_game_ctrl;

    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic          pause_i = 1'b0;
    logic [1:0]    dir_req_i = 2'b00;
    logic          dir_vld_i = 1'b0;
    logic          eat_i = 1'b0;
    logic          col_i = 1'b0;
    logic          mgr_rst_o;
    logic          mv_o;
    logic [1:0]    dir_o;
    logic          genf_o;
    logic [1:0]    state_o;
    logic [SW-1:0] score_o;
    logic [3:0]    level_o;
`ifdef SNAKE_HISCORE_EN
    logic [SW-1:0] hiscore_o;
`endif

    snake_game_ctrl #(
        .CNT_W(24), .BASE_PERIOD(8), .STEP(2), .MIN_PERIOD(3), .SCORE_W(SW), .LVL_SHIFT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .pause_i(pause_i),
        .dir_req_i(dir_req_i), .dir_vld_i(dir_vld_i), .eat_i(eat_i), .col_i(col_i),
        .mgr_rst_o(mgr_rst_o), .mv_o(mv_o), .dir_o(dir_o), .genf_o(genf_o),
        .state_o(state_o), .score_o(score_o), .level_o(level_o)
`ifdef SNAKE_HISCORE_EN
        , .hiscore_o(hiscore_o)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int tag; int st; int sc; int lv; int mr; int dr; int hi;
    } stat_t;
    typedef struct { int tag; int dr; } evt_t;

    stat_t sq[$];
    evt_t  mvq[$];
    evt_t  gfq[$];

    int checks = 0;
    int failures = 0;

    // Reference model, game-rule level: 0 IDLE, 1 RUN, 2 PAUSE, 3 OVER.
    int m_state = 0, m_cnt = 0, m_dir = 3, m_pend = 3;
    int m_score = 0, m_level = 0, m_hi = 0, m_mgr = 1;

    task automatic step(input bit rst, input bit st, input bit pa, input int dr,
                        input bit dv, input bit e, input bit c);
        bit mv;
        bit gf;
        int per;
        int old_dir;
        int old_pend;
        stat_t s;
        evt_t ev;
        logic [31:0] drv;
        @(negedge clk);
        drv = dr;
        rst_n = rst; start_i = st; pause_i = pa; dir_req_i = drv[1:0];
        dir_vld_i = dv; eat_i = e; col_i = c;

        mv = 0; gf = 0;
        old_dir = m_dir; old_pend = m_pend;
        if (!rst) begin
            m_state = 0; m_mgr = 1; m_dir = 3; m_pend = 3;
            m_score = 0; m_level = 0; m_cnt = 0; m_hi = 0;
        end else if (m_state == 0 || m_state == 3) begin
            if (st) begin
                m_mgr = (m_state == 3) ? 1 : 0;
                m_state = 1; m_score = 0; m_level = 0; m_cnt = 0; m_dir = 3; m_pend = 3;
            end else begin
                m_mgr = (m_state == 0) ? 1 : 0;
            end
        end else if (m_state == 1) begin
            m_mgr = 0;
            if (c) begin
                if (m_score > m_hi) m_hi = m_score;
                m_state = 3;
            end else begin
                per = 8 - 2 * m_level;
                if (per < 3) per = 3;
                if (e) begin
                    m_score = (m_score < 255) ? m_score + 1 : 255;
                    m_level = (m_score / 2 > 15) ? 15 : m_score / 2;
                    gf = 1;
                end
                if (pa) begin
                    m_state = 2;
                end else begin
                    if (m_cnt + 1 >= per) begin
                        mv = 1; m_cnt = 0; m_dir = old_pend;
                    end else begin
                        m_cnt++;
                    end
                    // Opposite of a direction differs only in bit 0.
                    if (dv && dr != (old_dir ^ 1)) m_pend = dr;
                end
            end
        end else begin
            if (pa) m_state = 1;
        end

        s.tag = cyc + 1; s.st = m_state; s.sc = m_score; s.lv = m_level;
        s.mr = m_mgr; s.dr = m_dir; s.hi = m_hi;
        sq.push_back(s);
        if (mv) begin ev.tag = cyc + 1; ev.dr = m_dir; mvq.push_back(ev); end
        if (gf) begin ev.tag = cyc + 1; ev.dr = 0; gfq.push_back(ev); end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: samples 2 time units after each rising edge.
    always begin
        stat_t e;
        evt_t ev;
        bit bad;
        @(posedge clk);
        #2;
        while (sq.size() > 0 && sq[0].tag < cyc) begin
            checks++; failures++;
            $display("FAIL status_missed tag=%0d now=%0d", sq[0].tag, cyc);
            void'(sq.pop_front());
        end
        if (sq.size() > 0 && sq[0].tag == cyc) begin
            e = sq.pop_front();
            bad = (int'(state_o) != e.st) || (int'(score_o) != e.sc) || (int'(level_o) != e.lv)
                  || (int'(mgr_rst_o) != e.mr) || (int'(dir_o) != e.dr);
`ifdef SNAKE_HISCORE_EN
            bad = bad || (int'(hiscore_o) != e.hi);
`endif
            checks++;
            if (bad) begin
                failures++;
                $display("FAIL status cyc=%0d got st=%0d sc=%0d lv=%0d mr=%0d dir=%0d exp st=%0d sc=%0d lv=%0d mr=%0d dir=%0d hi=%0d",
                         cyc, state_o, score_o, level_o, mgr_rst_o, dir_o,
                         e.st, e.sc, e.lv, e.mr, e.dr, e.hi);
            end
        end
        while (mvq.size() > 0 && mvq[0].tag < cyc) begin
            checks++; failures++;
            $display("FAIL mv_missing exp_cyc=%0d now=%0d", mvq[0].tag, cyc);
            void'(mvq.pop_front());
        end
        if (mv_o) begin
            checks++;
            if (mvq.size() > 0 && mvq[0].tag == cyc) begin
                ev = mvq.pop_front();
                if (int'(dir_o) != ev.dr) begin
                    failures++;
                    $display("FAIL mv_dir cyc=%0d got=%0d exp=%0d", cyc, dir_o, ev.dr);
                end
            end else begin
                failures++;
                $display("FAIL mv_unexpected cyc=%0d got=1 exp=0", cyc);
            end
        end
        while (gfq.size() > 0 && gfq[0].tag < cyc) begin
            checks++; failures++;
            $display("FAIL genf_missing exp_cyc=%0d now=%0d", gfq[0].tag, cyc);
            void'(gfq.pop_front());
        end
        if (genf_o) begin
            checks++;
            if (gfq.size() > 0 && gfq[0].tag == cyc) begin
                void'(gfq.pop_front());
            end else begin
                failures++;
                $display("FAIL genf_unexpected cyc=%0d got=1 exp=0", cyc);
            end
        end
    end

    initial begin
        // Reset, start, first moves.
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        idle(18);
        // Reversal attempt, then two requests before the same move.
        step(1, 0, 0, 2, 1, 0, 0);
        idle(8);
        step(1, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 1, 0, 0);
        idle(10);
        // Eats raise level and shorten the period; more eats hit the floor.
        step(1, 0, 0, 0, 0, 1, 0);
        idle(2);
        step(1, 0, 0, 0, 0, 1, 0);
        idle(14);
        for (int k = 0; k < 6; k++) step(1, 0, 0, 0, 0, 1, 0);
        idle(10);
        // Pause/resume and ignored inputs while paused.
        step(1, 0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 20; k++) step(1, k == 3, 0, 2, 1, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0);
        idle(6);
        // Eat then collision next cycle: genf still issues.
        step(1, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 1);
        idle(8);
        step(1, 1, 0, 0, 0, 0, 0);
        idle(5);
        // Two games for the high score: 3 then 1.
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 1, 1);
        idle(3);
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 1);
        idle(3);
        step(0, 0, 0, 0, 0, 0, 0);
        idle(3);
        // Long game to reach score saturation and level cap.
        step(1, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 700; k++)
            step(1, 0, 0, $urandom_range(0, 3), $urandom_range(0, 2) == 0,
                 $urandom_range(0, 1) == 1, 0);
        // Randomized play including mid-game resets.
        for (int k = 0; k < 4000; k++)
            step($urandom_range(0, 799) != 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 3),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 149) == 0);
        idle(2);
        @(posedge clk); #3;
        @(posedge clk); #3;
        checks++;
        if (sq.size() + mvq.size() + gfq.size() != 0) begin
            failures++;
            $display("FAIL drain left status=%0d mv=%0d genf=%0d exp=0", sq.size(), mvq.size(), gfq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
